// File: rtl/prod_accum.sv
// prod_accum: accumulates fixed-length groups of LEN signed products into a
// wrapping ACC_W-bit dot-product sum, with a per-group sticky signed-overflow
// flag. One result per group, flagged by a single-cycle out_valid pulse.
//
// Handshake: no backpressure. A product is accepted on every rising edge where
// in_valid=1 and clear=0; out_valid is a one-cycle strobe with no ready, and
// out_sum/out_ovf hold their last reported values between strobes.
//
// The group-position counter 'count' is the only control state; it is exported
// directly so checkers can observe the group position every cycle.
module prod_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8,
  parameter int CNT_W  = $clog2(LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              clear,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] next_sum;
  logic             add_ovf;
  logic             at_last;
  logic             accept;

  // Sign-extend the product, form the wrapping sum and detect signed overflow:
  // equal operand signs with a result sign that differs from them.
  always_comb begin
    ext      = ACC_W'($signed(in_prod));
    next_sum = acc + ext;
    add_ovf  = (acc[ACC_W-1] == ext[ACC_W-1]) &&
               (next_sum[ACC_W-1] != acc[ACC_W-1]);
    at_last  = (count == CNT_W'(LEN - 1));
    accept   = in_valid && !clear;
  end

  // Group state and result registers; reset dominates, then clear, then accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        // Abort the partial group; the last reported result stays visible.
        acc        <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
      end else if (accept) begin
        if (count == '0) begin
          // First product of a group loads rather than adds, so the previous
          // group's sum never leaks in and back-to-back groups need no gap.
          acc        <= ext;
          ovf_sticky <= 1'b0;
          count      <= CNT_W'(1);
        end else if (at_last) begin
          acc       <= next_sum;
          out_sum   <= next_sum;
          out_ovf   <= ovf_sticky | add_ovf;
          out_valid <= 1'b1;
          count     <= '0;
        end else begin
          acc        <= next_sum;
          ovf_sticky <= ovf_sticky | add_ovf;
          count      <= count + CNT_W'(1);
        end
      end
    end
  end

  // A partial group is held whenever the registered position is non-zero.
  always_comb begin
    busy = (count != '0);
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed table of per-cycle vectors for the default
// configuration, plus hand-written sequences for wrap/overflow on an 18-bit
// accumulator and for reset in the middle of a group.
module tb_prod_accum;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        clear;

  logic        out_valid;
  logic [23:0] out_sum;
  logic        out_ovf;
  logic        busy;
  logic [2:0]  count;

  logic        out_valid_n;
  logic [17:0] out_sum_n;
  logic        out_ovf_n;
  logic        busy_n;
  logic [2:0]  count_n;

  int n_tests = 0;
  int n_fail  = 0;

  prod_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .clear     (clear),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .count     (count)
  );

  prod_accum #(.ACC_W(18)) dut_n (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .clear     (clear),
    .out_valid (out_valid_n),
    .out_sum   (out_sum_n),
    .out_ovf   (out_ovf_n),
    .busy      (busy_n),
    .count     (count_n)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit rst;
    bit vld;
    bit clr;
    int prod;
    bit e_valid;
    int e_count;
    int e_sum;
    bit e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit vld, bit clr, int prod,
                              bit e_valid, int e_count, int e_sum, bit e_ovf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.clr = clr; v.prod = prod;
    v.e_valid = e_valid; v.e_count = e_count; v.e_sum = e_sum; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and wait until just after the sampling edge.
  task automatic drive(input bit rst, input bit vld, input bit clr, input int prod);
    reset    = rst;
    in_valid = vld;
    clear    = clr;
    in_prod  = 16'(prod);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int valid_seen;

    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; in_prod = '0;

    // Reset, then 8 x 100 -> 800
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 100, 0, i, 0, 0);
    add(0, 1, 0, 100, 1, 0, 800, 0);
    add(0, 0, 0, 0,   0, 0, 800, 0);

    // Alternating +/-16384 with a 3-cycle gap after the 4th product -> 0
    add(0, 1, 0,  16384, 0, 1, 800, 0);
    add(0, 1, 0, -16384, 0, 2, 800, 0);
    add(0, 1, 0,  16384, 0, 3, 800, 0);
    add(0, 1, 0, -16384, 0, 4, 800, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 4, 800, 0);
    add(0, 1, 0,  16384, 0, 5, 800, 0);
    add(0, 1, 0, -16384, 0, 6, 800, 0);
    add(0, 1, 0,  16384, 0, 7, 800, 0);
    add(0, 1, 0, -16384, 1, 0, 0, 0);
    add(0, 0, 0, 0,      0, 0, 0, 0);

    // Back-to-back groups 1..8 then -1..-8
    for (int i = 1; i <= 7; i++) add(0, 1, 0, i, 0, i, 0, 0);
    add(0, 1, 0, 8, 1, 0, 36, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, -i, 0, i, 36, 0);
    add(0, 1, 0, -8, 1, 0, -36, 0);
    add(0, 0, 0, 0,  0, 0, -36, 0);

    // 5 x 1000, clear with a dropped product, then 8 x 2 -> 16
    for (int i = 1; i <= 5; i++) add(0, 1, 0, 1000, 0, i, -36, 0);
    add(0, 1, 1, 7, 0, 0, -36, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 2, 0, i, -36, 0);
    add(0, 1, 0, 2, 1, 0, 16, 0);
    add(0, 0, 0, 0, 0, 0, 16, 0);

    // Clear coinciding with the LEN-th product: no result
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 3, 0, i, 16, 0);
    add(0, 1, 1, 3, 0, 0, 16, 0);
    add(0, 0, 0, 0, 0, 0, 16, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].vld, vecs[k].clr, vecs[k].prod);
      check($sformatf("row%0d out_valid", k), int'(out_valid), int'(vecs[k].e_valid));
      check($sformatf("row%0d count", k), int'(count), vecs[k].e_count);
      check($sformatf("row%0d busy", k), int'(busy), int'(vecs[k].e_count != 0));
      check($sformatf("row%0d out_sum", k), int'($signed(out_sum)), vecs[k].e_sum);
      check($sformatf("row%0d out_ovf", k), int'(out_ovf), int'(vecs[k].e_ovf));
    end

    // Wrap on 18-bit accumulator: 8 x 16384 -> -131072 with overflow
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 16384);
    check("ovf18 pre count", int'(count_n), 7);
    drive(0, 1, 0, 16384);
    check("ovf18 out_valid", int'(out_valid_n), 1);
    check("ovf18 out_sum", int'($signed(out_sum_n)), -131072);
    check("ovf18 out_ovf", int'(out_ovf_n), 1);
    check("ovf24 out_sum", int'($signed(out_sum)), 131072);
    check("ovf24 out_ovf", int'(out_ovf), 0);
    // Next group clears the sticky flag
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 1);
    check("grp2_18 out_valid", int'(out_valid_n), 1);
    check("grp2_18 out_sum", int'($signed(out_sum_n)), 8);
    check("grp2_18 out_ovf", int'(out_ovf_n), 0);
    check("grp2_24 out_sum", int'($signed(out_sum)), 8);
    drive(0, 0, 0, 0);
    check("grp2 pulse width", int'(out_valid_n), 0);
    check("grp2 held ovf18", int'(out_ovf_n), 0);

    // Reset mid-group, then 8 x -5 -> -40 with a single strobe
    for (int i = 0; i < 3; i++) drive(0, 1, 0, -5);
    check("midrst busy before", int'(busy), 1);
    drive(1, 1, 0, -5);
    check("midrst out_sum", int'($signed(out_sum)), 0);
    check("midrst out_ovf", int'(out_ovf), 0);
    check("midrst count", int'(count), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst out_valid", int'(out_valid), 0);
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, -5);
      if (out_valid) valid_seen++;
    end
    check("after rst out_sum", int'($signed(out_sum)), -40);
    check("after rst out_ovf", int'(out_ovf), 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      if (out_valid) valid_seen++;
    end
    check("after rst strobes", valid_seen, 1);
    check("after rst held sum", int'($signed(out_sum)), -40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
